// File: rtl/hsst_tx_burst_sched.sv
// HSST TX burst scheduler: drains fixed-length bursts from the staging FIFO
// and frames them with comma/SOF/EOF control words for the TX lane.
module hsst_tx_burst_sched #(
  parameter int BURST_LEN = 256,
  parameter int GAP_LEN   = 4,
  parameter int LVL_W     = 12
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             link_ready,
  output logic             fifo_rd_en,
  input  logic [15:0]      fifo_rd_data,
  input  logic             fifo_rd_empty,
  input  logic [LVL_W-1:0] fifo_rd_water_level,
  output logic [15:0]      tx_data,
  output logic [1:0]       tx_kchar,
  output logic [15:0]      burst_cnt,
  output logic             underrun
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_SOF     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_EOF     = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  localparam logic [15:0] IDLE_W = 16'h50BC;
  localparam logic [7:0]  K_SOF  = 8'hFB;
  localparam logic [7:0]  K_EOF  = 8'hFD;

  localparam logic [LVL_W-1:0] LVL_MIN = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] RD_LAST = LVL_W'(BURST_LEN - 1);
  localparam logic [LVL_W-1:0] RD_ONE  = LVL_W'(1);
  localparam logic [15:0]      GAP_INI = 16'(GAP_LEN - 1);

  logic [2:0]       state;
  logic [LVL_W-1:0] rd_left;
  logic             rd_zero;
  logic [15:0]      gap_cnt;
  logic [7:0]       seq;
  logic [7:0]       csum;
  logic             start;
  logic [15:0]      pl_word;

  assign start = link_ready
              && (fifo_rd_water_level >= LVL_MIN)
              && (gap_cnt == 16'd0);

  // an empty read still costs a payload slot; it is sent as zero
  assign pl_word = rd_zero ? 16'h0000 : fifo_rd_data;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state      <= S_IDLE;
      fifo_rd_en <= 1'b0;
      rd_left    <= '0;
      rd_zero    <= 1'b0;
      gap_cnt    <= 16'd0;
      seq        <= 8'd0;
      csum       <= 8'd0;
      tx_data    <= IDLE_W;
      tx_kchar   <= 2'b01;
      burst_cnt  <= 16'd0;
      underrun   <= 1'b0;
    end else begin
      rd_zero <= fifo_rd_en & fifo_rd_empty;
      if (fifo_rd_en & fifo_rd_empty)
        underrun <= 1'b1;
      if (fifo_rd_en) begin
        if (rd_left == '0)
          fifo_rd_en <= 1'b0;
        else
          rd_left <= rd_left - RD_ONE;
      end
      case (state)
        S_IDLE: begin
          tx_data  <= IDLE_W;
          tx_kchar <= 2'b01;
          if (start) begin
            state      <= S_ARM;
            fifo_rd_en <= 1'b1;
            rd_left    <= RD_LAST;
          end
        end
        S_ARM: begin
          tx_data  <= {seq, K_SOF};
          tx_kchar <= 2'b01;
          csum     <= 8'd0;
          state    <= S_SOF;
        end
        S_SOF, S_PAYLOAD: begin
          tx_data  <= pl_word;
          tx_kchar <= 2'b00;
          csum     <= csum ^ pl_word[15:8] ^ pl_word[7:0];
          // read enable already low means this is the last word
          state    <= fifo_rd_en ? S_PAYLOAD : S_EOF;
        end
        S_EOF: begin
          tx_data   <= {csum, K_EOF};
          tx_kchar  <= 2'b01;
          burst_cnt <= burst_cnt + 16'd1;
          seq       <= seq + 8'd1;
          gap_cnt   <= GAP_INI;
          state     <= (GAP_LEN > 1) ? S_GAP : S_IDLE;
        end
        S_GAP: begin
          tx_data  <= IDLE_W;
          tx_kchar <= 2'b01;
          gap_cnt  <= gap_cnt - 16'd1;
          if (gap_cnt <= 16'd1)
            state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          tx_data  <= IDLE_W;
          tx_kchar <= 2'b01;
        end
      endcase
    end
  end

endmodule
